dram_resp_addr_composer: RTL and testbench

- Return-path counterpart of the L2-to-DRAM address translator.
- Accepts DRAM completions tagged with decoded fields (offset, bank_id, row_id, col_id) and recomposes the flat L2 address.
- Buffers completions in a small FIFO and returns them to the L2 with a valid/ready handshake.
- Sits between the DRAM command/bank scheduler (completion side) and the L2 response port.

---
 rtl/dram_resp_addr_composer.sv | 122 ++++++++++++
 tb/tb_dram_resp_addr_composer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dram_resp_addr_composer.sv
// Return-path address composer: rebuilds flat L2 addresses from decoded DRAM
// completion fields and queues the responses toward the L2 in a small FIFO.
module dram_resp_addr_composer #(
    parameter int unsigned ADDR_WIDTH   = 20,
    parameter int unsigned NUM_OF_BANKS = 8,
    parameter int unsigned NUM_OF_ROWS  = 128,
    parameter int unsigned NUM_OF_COLS  = 8,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               dram_resp_valid,
    output logic                               dram_resp_ready,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]     dram_resp_offset,
    input  logic [$clog2(NUM_OF_BANKS)-1:0]    dram_resp_bank_id,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]     dram_resp_row_id,
    input  logic [$clog2(NUM_OF_COLS)-1:0]     dram_resp_col_id,
    input  logic                               dram_resp_is_write,
    input  logic [DATA_WIDTH-1:0]              dram_resp_data,
    output logic                               l2_resp_valid,
    input  logic                               l2_resp_ready,
    output logic [ADDR_WIDTH-1:0]              l2_resp_address,
    output logic                               l2_resp_is_write,
    output logic [DATA_WIDTH-1:0]              l2_resp_data,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
    output logic [15:0]                        resp_total
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  is_write;
        logic [DATA_WIDTH-1:0] data;
    } resp_entry_t;

    resp_entry_t       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [15:0]       r_total;

    logic              w_ready;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    resp_entry_t       w_entry;
    resp_entry_t       w_head;

    assign w_ready = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_valid = (r_count != '0);
    assign w_push  = dram_resp_valid & w_ready;
    assign w_pop   = w_valid & l2_resp_ready;

    // Inverse of the forward translator: {offset, bank, row, col}, MSB first.
    always_comb begin
        w_entry          = '0;
        w_entry.addr     = ADDR_WIDTH'({dram_resp_offset, dram_resp_bank_id,
                                        dram_resp_row_id, dram_resp_col_id});
        w_entry.is_write = dram_resp_is_write;
        w_entry.data     = dram_resp_is_write ? '0 : dram_resp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Delivered-response counter saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= '0;
        end else if (w_pop && (r_total != 16'hFFFF)) begin
            r_total <= r_total + 16'd1;
        end
    end

    // Head entry is masked while empty so stale storage never leaks out.
    always_comb begin
        w_head = '0;
        if (w_valid) begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    assign dram_resp_ready  = w_ready;
    assign l2_resp_valid    = w_valid;
    assign l2_resp_address  = w_head.addr;
    assign l2_resp_is_write = w_head.is_write;
    assign l2_resp_data     = w_head.data;
    assign fifo_count       = r_count;
    assign resp_total       = r_total;

endmodule

// File: tb/tb_dram_resp_addr_composer.sv
// Directed self-checking bench for dram_resp_addr_composer (default parameters).
module tb_dram_resp_addr_composer;

    logic        clk;
    logic        rst_n;
    logic        dram_resp_valid;
    logic        dram_resp_ready;
    logic [6:0]  dram_resp_offset;
    logic [2:0]  dram_resp_bank_id;
    logic [6:0]  dram_resp_row_id;
    logic [2:0]  dram_resp_col_id;
    logic        dram_resp_is_write;
    logic [63:0] dram_resp_data;
    logic        l2_resp_valid;
    logic        l2_resp_ready;
    logic [19:0] l2_resp_address;
    logic        l2_resp_is_write;
    logic [63:0] l2_resp_data;
    logic [2:0]  fifo_count;
    logic [15:0] resp_total;

    int n_checks = 0;
    int n_fails  = 0;

    dram_resp_addr_composer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dram_resp_valid    (dram_resp_valid),
        .dram_resp_ready    (dram_resp_ready),
        .dram_resp_offset   (dram_resp_offset),
        .dram_resp_bank_id  (dram_resp_bank_id),
        .dram_resp_row_id   (dram_resp_row_id),
        .dram_resp_col_id   (dram_resp_col_id),
        .dram_resp_is_write (dram_resp_is_write),
        .dram_resp_data     (dram_resp_data),
        .l2_resp_valid      (l2_resp_valid),
        .l2_resp_ready      (l2_resp_ready),
        .l2_resp_address    (l2_resp_address),
        .l2_resp_is_write   (l2_resp_is_write),
        .l2_resp_data       (l2_resp_data),
        .fifo_count         (fifo_count),
        .resp_total         (resp_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] off, input logic [2:0] bank,
                         input logic [6:0] row, input logic [2:0] col,
                         input logic wr, input logic [63:0] data);
        dram_resp_valid    = v;
        dram_resp_offset   = off;
        dram_resp_bank_id  = bank;
        dram_resp_row_id   = row;
        dram_resp_col_id   = col;
        dram_resp_is_write = wr;
        dram_resp_data     = data;
    endtask

    // Hand-computed addresses for fields offset=bank=row=col=i, i=1..5.
    logic [19:0] fill_addr [5];
    logic [19:0] exp_a;

    initial begin
        fill_addr[0] = 20'h02409;
        fill_addr[1] = 20'h04812;
        fill_addr[2] = 20'h06C1B;
        fill_addr[3] = 20'h09024;
        fill_addr[4] = 20'h0B42D;

        rst_n = 1'b0;
        l2_resp_ready = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 7'd0, 3'd0, 1'b0, 64'd0);
        #3;
        chk_eq("rst_valid", 64'(l2_resp_valid), 64'd0);
        chk_eq("rst_ready", 64'(dram_resp_ready), 64'd1);
        chk_eq("rst_count", 64'(fifo_count), 64'd0);
        chk_eq("rst_total", 64'(resp_total), 64'd0);
        chk_eq("rst_addr", 64'(l2_resp_address), 64'd0);
        chk_eq("rst_data", l2_resp_data, 64'd0);
        chk_eq("rst_wr", 64'(l2_resp_is_write), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single read, one-cycle latency
        drive(1'b1, 7'h05, 3'd6, 7'h12, 3'd3, 1'b0, 64'hDEADBEEF);
        tick();
        drive(1'b0, 7'd0, 3'd0, 7'd0, 3'd0, 1'b0, 64'd0);
        chk_eq("rd_valid", 64'(l2_resp_valid), 64'd1);
        chk_eq("rd_addr", 64'(l2_resp_address), 64'h0B893);
        chk_eq("rd_data", l2_resp_data, 64'hDEADBEEF);
        chk_eq("rd_wr", 64'(l2_resp_is_write), 64'd0);
        chk_eq("rd_count", 64'(fifo_count), 64'd1);
        l2_resp_ready = 1'b1;
        tick();
        l2_resp_ready = 1'b0;
        chk_eq("rd_pop_valid", 64'(l2_resp_valid), 64'd0);
        chk_eq("rd_pop_total", 64'(resp_total), 64'd1);

        // Write ack: data forced to zero
        drive(1'b1, 7'd0, 3'd7, 7'h7F, 3'd7, 1'b1, 64'hFFFF);
        tick();
        drive(1'b0, 7'd0, 3'd0, 7'd0, 3'd0, 1'b0, 64'd0);
        chk_eq("wr_addr", 64'(l2_resp_address), 64'h01FFF);
        chk_eq("wr_data", l2_resp_data, 64'd0);
        chk_eq("wr_flag", 64'(l2_resp_is_write), 64'd1);
        l2_resp_ready = 1'b1;
        tick();
        l2_resp_ready = 1'b0;
        chk_eq("wr_total", 64'(resp_total), 64'd2);

        // Fill to full under backpressure, 5th request held off
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 7'(i), 3'(i), 7'(i), 3'(i), 1'b0, 64'h1000 + 64'(i));
            tick();
        end
        chk_eq("full_count", 64'(fifo_count), 64'd4);
        chk_eq("full_ready", 64'(dram_resp_ready), 64'd0);
        drive(1'b1, 7'd5, 3'd5, 7'd5, 3'd5, 1'b0, 64'h1005);
        tick();
        tick();
        chk_eq("full_hold_count", 64'(fifo_count), 64'd4);
        chk_eq("full_hold_ready", 64'(dram_resp_ready), 64'd0);
        chk_eq("drain_head0", 64'(l2_resp_address), 64'(fill_addr[0]));
        chk_eq("drain_data0", l2_resp_data, 64'h1001);
        l2_resp_ready = 1'b1;
        tick();
        chk_eq("drain_ready_back", 64'(dram_resp_ready), 64'd1);
        chk_eq("drain_count_a", 64'(fifo_count), 64'd3);
        chk_eq("drain_head1", 64'(l2_resp_address), 64'(fill_addr[1]));
        tick();
        drive(1'b0, 7'd0, 3'd0, 7'd0, 3'd0, 1'b0, 64'd0);
        chk_eq("drain_count_b", 64'(fifo_count), 64'd3);
        for (int i = 2; i < 5; i++) begin
            chk_eq("drain_head", 64'(l2_resp_address), 64'(fill_addr[i]));
            chk_eq("drain_data", l2_resp_data, 64'h1001 + 64'(i));
            tick();
        end
        chk_eq("drain_empty", 64'(l2_resp_valid), 64'd0);
        chk_eq("drain_total", 64'(resp_total), 64'd7);
        l2_resp_ready = 1'b0;

        // Steady push+pop at count=2; address = {row=k, col=k%8}
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 7'd0, 3'd0, 7'(k), 3'(k), 1'b0, 64'(k));
            tick();
        end
        l2_resp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 7'd0, 3'd0, 7'(k + 2), 3'(k + 2), 1'b0, 64'(k + 2));
            exp_a = 20'((k << 3) | (k & 7));
            chk_eq("pp_count", 64'(fifo_count), 64'd2);
            chk_eq("pp_addr", 64'(l2_resp_address), 64'(exp_a));
            chk_eq("pp_data", l2_resp_data, 64'(k));
            tick();
        end
        drive(1'b0, 7'd0, 3'd0, 7'd0, 3'd0, 1'b0, 64'd0);
        for (int k = 10; k < 12; k++) begin
            exp_a = 20'((k << 3) | (k & 7));
            chk_eq("pp_tail_addr", 64'(l2_resp_address), 64'(exp_a));
            tick();
        end
        chk_eq("pp_empty", 64'(fifo_count), 64'd0);
        chk_eq("pp_total", 64'(resp_total), 64'd19);
        l2_resp_ready = 1'b0;

        // Asynchronous reset with three entries queued
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 7'(i), 3'(i), 7'(i), 3'(i), 1'b0, 64'(i));
            tick();
        end
        drive(1'b0, 7'd0, 3'd0, 7'd0, 3'd0, 1'b0, 64'd0);
        chk_eq("pre_rst_count", 64'(fifo_count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_valid", 64'(l2_resp_valid), 64'd0);
        chk_eq("arst_count", 64'(fifo_count), 64'd0);
        chk_eq("arst_total", 64'(resp_total), 64'd0);
        chk_eq("arst_ready", 64'(dram_resp_ready), 64'd1);
        chk_eq("arst_addr", 64'(l2_resp_address), 64'd0);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 7'h05, 3'd6, 7'h12, 3'd3, 1'b0, 64'h55);
        tick();
        drive(1'b0, 7'd0, 3'd0, 7'd0, 3'd0, 1'b0, 64'd0);
        chk_eq("post_rst_valid", 64'(l2_resp_valid), 64'd1);
        chk_eq("post_rst_addr", 64'(l2_resp_address), 64'h0B893);
        chk_eq("post_rst_count", 64'(fifo_count), 64'd1);
        l2_resp_ready = 1'b1;
        tick();
        chk_eq("post_rst_total", 64'(resp_total), 64'd1);

        // Saturation: first edge pushes only, each later edge pops once
        drive(1'b1, 7'd1, 3'd1, 7'd1, 3'd1, 1'b0, 64'd1);
        for (int n = 0; n < 65534; n++) begin
            tick();
        end
        chk_eq("sat_fffe", 64'(resp_total), 64'hFFFE);
        tick();
        chk_eq("sat_ffff", 64'(resp_total), 64'hFFFF);
        tick();
        tick();
        chk_eq("sat_hold", 64'(resp_total), 64'hFFFF);
        drive(1'b0, 7'd0, 3'd0, 7'd0, 3'd0, 1'b0, 64'd0);
        tick();
        chk_eq("sat_end_count", 64'(fifo_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
